// File: rtl/axi_lite_regtest_master_if.sv
// AXI4-Lite master-side bus bundle for the register self-test master.
// The master modport drives requests; the slave modport answers them.
interface axi_lite_regtest_master_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] M_AXI_AWADDR;
  logic [2:0]        M_AXI_AWPROT;
  logic              M_AXI_AWVALID;
  logic              M_AXI_AWREADY;
  logic [31:0]       M_AXI_WDATA;
  logic [3:0]        M_AXI_WSTRB;
  logic              M_AXI_WVALID;
  logic              M_AXI_WREADY;
  logic [1:0]        M_AXI_BRESP;
  logic              M_AXI_BVALID;
  logic              M_AXI_BREADY;
  logic [ADDR_W-1:0] M_AXI_ARADDR;
  logic [2:0]        M_AXI_ARPROT;
  logic              M_AXI_ARVALID;
  logic              M_AXI_ARREADY;
  logic [31:0]       M_AXI_RDATA;
  logic [1:0]        M_AXI_RRESP;
  logic              M_AXI_RVALID;
  logic              M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_regtest_master.sv
// AXI4-Lite register self-test master: write, read back, compare per register.
// Optional macro REGTEST_STOP_ON_ERR_EN ends the run at the first failing register.
module axi_lite_regtest_master #(
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR          = 32'h0000_0000,
  parameter int          NUM_REGS           = 4,
  parameter logic [31:0] ADDR_STRIDE        = 32'd4,
  parameter logic [31:0] PAT_INC            = 32'h0101_0101
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        start,
  input  logic [31:0] seed,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  fail_index,
  output logic [31:0] last_rdata,
  axi_lite_regtest_master_if.master m_axi
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE, WRITE, WRESP, RADDR, RDATA, NEXT, FINISH
  } state_t;

  state_t state, state_n;

  logic [AW-1:0] addr;
  logic [DW-1:0] pattern;
  logic [3:0]    idx;
  logic          aw_done;
  logic          w_done;
  logic          wr_err;
  logic          cur_fail;
  logic          take;
  logic          aw_fire;
  logic          w_fire;
  logic          last;
  logic          stop;

  assign take = start && (state == IDLE || state == FINISH);
  assign last = (idx == LAST_IDX);

`ifdef REGTEST_STOP_ON_ERR_EN
  assign stop = last || (cur_fail && err_count == 5'd0);
`else
  assign stop = last;
`endif

  assign m_axi.M_AXI_AWADDR  = addr;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = (state == WRITE) && !aw_done;
  assign m_axi.M_AXI_WDATA   = pattern;
  assign m_axi.M_AXI_WSTRB   = 4'hF;
  assign m_axi.M_AXI_WVALID  = (state == WRITE) && !w_done;
  assign m_axi.M_AXI_BREADY  = (state == WRESP);
  assign m_axi.M_AXI_ARADDR  = addr;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = (state == RADDR);
  assign m_axi.M_AXI_RREADY  = (state == RDATA);

  assign aw_fire = m_axi.M_AXI_AWVALID && m_axi.M_AXI_AWREADY;
  assign w_fire  = m_axi.M_AXI_WVALID && m_axi.M_AXI_WREADY;

  assign busy = !(state == IDLE || state == FINISH);
  assign done = (state == FINISH);
  assign pass = done && (err_count == 5'd0);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, FINISH: if (take) state_n = WRITE;
      WRITE:
        if ((aw_done || aw_fire) && (w_done || w_fire))
          state_n = WRESP;
      WRESP: if (m_axi.M_AXI_BVALID) state_n = RADDR;
      RADDR: if (m_axi.M_AXI_ARREADY) state_n = RDATA;
      RDATA: if (m_axi.M_AXI_RVALID) state_n = NEXT;
      NEXT:  state_n = stop ? FINISH : WRITE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      addr       <= AW'(BASE_ADDR);
      pattern    <= '0;
      idx        <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      wr_err     <= 1'b0;
      cur_fail   <= 1'b0;
      err_count  <= '0;
      fail_index <= '0;
      last_rdata <= '0;
    end else begin
      if (take) begin
        addr       <= AW'(BASE_ADDR);
        pattern    <= DW'(seed);
        idx        <= '0;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
        err_count  <= '0;
        fail_index <= '0;
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
      if (state == WRESP && m_axi.M_AXI_BVALID)
        wr_err <= (m_axi.M_AXI_BRESP != 2'b00);
      if (state == RDATA && m_axi.M_AXI_RVALID) begin
        last_rdata <= 32'(m_axi.M_AXI_RDATA);
        cur_fail   <= wr_err
                   || (m_axi.M_AXI_RRESP != 2'b00)
                   || (m_axi.M_AXI_RDATA != pattern);
      end
      if (state == NEXT) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (cur_fail) begin
          if (err_count != 5'd31) err_count <= err_count + 5'd1;
          if (err_count == 5'd0)  fail_index <= idx;
        end
        if (!stop) begin
          idx     <= idx + 4'd1;
          addr    <= addr + AW'(ADDR_STRIDE);
          pattern <= pattern + DW'(PAT_INC);
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_regtest_master.sv
// Self-checking bench: randomized AXI-Lite echo slave with stalls and faults,
// compared against an arithmetic model of the register test run.
module tb_axi_lite_regtest_master;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] STRIDE = 32'd4;
  localparam logic [31:0] INC    = 32'h0101_0101;
  localparam int          NR     = 4;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic [31:0] seed;
  logic        busy, done, pass;
  logic [4:0]  err_count;
  logic [3:0]  fail_index;
  logic [31:0] last_rdata;

  axi_lite_regtest_master_if bus ();

  axi_lite_regtest_master #(
    .BASE_ADDR(BASE), .NUM_REGS(NR),
    .ADDR_STRIDE(STRIDE), .PAT_INC(INC)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_index(fail_index),
    .last_rdata(last_rdata), .m_axi(bus)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  // slave configuration (written by the test sequence only)
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  int corrupt_idx = -1, bresp_idx = -1, rresp_idx = -1;

  // slave state and logs (written by the slave process only)
  logic [31:0] mem [16];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [31:0] rd_addr_q [$];
  int aw_cnt = 0, w_cnt = 0, proto_err = 0;
  int aw_w, w_w, ar_w, r_w;
  bit aw_have, w_have, ar_have;
  bit aw_f, w_f, b_f, ar_f, r_f;
  bit p_awv, p_wv, p_arv;
  logic [31:0] p_awa, p_wd, p_ara, aw_a, w_d, ar_a;

  function automatic int ridx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return int'(off[3:0]);
  endfunction

  always @(negedge ACLK) begin
    if (ARESET) begin
      bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0;
      bus.M_AXI_BVALID = 1'b0;  bus.M_AXI_BRESP = 2'b00;
      bus.M_AXI_ARREADY = 1'b0; bus.M_AXI_RVALID = 1'b0;
      bus.M_AXI_RDATA = 32'h0;  bus.M_AXI_RRESP = 2'b00;
      aw_have = 0; w_have = 0; ar_have = 0;
      aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0;
      p_awv = 0; p_wv = 0; p_arv = 0;
      aw_w = 0; w_w = 0; ar_w = 0; r_w = 0;
      for (int k = 0; k < 16; k++) mem[k] = 32'h0;
    end else begin
      if (aw_f) begin bus.M_AXI_AWREADY = 1'b0; aw_f = 0; end
      if (w_f)  begin bus.M_AXI_WREADY = 1'b0;  w_f = 0;  end
      if (b_f)  begin bus.M_AXI_BVALID = 1'b0;  b_f = 0;  end
      if (ar_f) begin bus.M_AXI_ARREADY = 1'b0; ar_f = 0; end
      if (r_f)  begin bus.M_AXI_RVALID = 1'b0;  r_f = 0;  end
      // a VALID seen without acceptance must hold with stable payload
      if (p_awv && (!bus.M_AXI_AWVALID || bus.M_AXI_AWADDR != p_awa))
        proto_err++;
      if (p_wv && (!bus.M_AXI_WVALID || bus.M_AXI_WDATA != p_wd))
        proto_err++;
      if (p_arv && (!bus.M_AXI_ARVALID || bus.M_AXI_ARADDR != p_ara))
        proto_err++;
      if (aw_have && w_have && !bus.M_AXI_BVALID) begin
        mem[ridx(aw_a)] = w_d;
        wr_addr_q.push_back(aw_a);
        wr_data_q.push_back(w_d);
        bus.M_AXI_BRESP = (ridx(aw_a) == bresp_idx) ? 2'b10 : 2'b00;
        bus.M_AXI_BVALID = 1'b1;
        aw_have = 0; w_have = 0;
      end
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) b_f = 1;
      if (bus.M_AXI_AWVALID && !aw_have && !bus.M_AXI_AWREADY) begin
        if (aw_w >= aw_dly) bus.M_AXI_AWREADY = 1'b1;
        else aw_w++;
      end
      if (bus.M_AXI_AWREADY && bus.M_AXI_AWVALID) begin
        aw_f = 1; aw_have = 1; aw_a = bus.M_AXI_AWADDR; aw_cnt++; aw_w = 0;
        if (bus.M_AXI_AWPROT != 3'b000) proto_err++;
      end
      if (bus.M_AXI_WVALID && !w_have && !bus.M_AXI_WREADY) begin
        if (w_w >= w_dly) bus.M_AXI_WREADY = 1'b1;
        else w_w++;
      end
      if (bus.M_AXI_WREADY && bus.M_AXI_WVALID) begin
        w_f = 1; w_have = 1; w_d = bus.M_AXI_WDATA; w_cnt++; w_w = 0;
        if (bus.M_AXI_WSTRB != 4'hF) proto_err++;
      end
      if (ar_have && !bus.M_AXI_RVALID) begin
        if (r_w >= r_dly) begin
          bus.M_AXI_RVALID = 1'b1;
          bus.M_AXI_RDATA = (ridx(ar_a) == corrupt_idx) ?
                            32'hDEAD_0011 : mem[ridx(ar_a)];
          bus.M_AXI_RRESP = (ridx(ar_a) == rresp_idx) ? 2'b10 : 2'b00;
          ar_have = 0;
        end else r_w++;
      end
      if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) r_f = 1;
      if (bus.M_AXI_ARVALID && !ar_have && !bus.M_AXI_ARREADY) begin
        if (ar_w >= ar_dly) bus.M_AXI_ARREADY = 1'b1;
        else ar_w++;
      end
      if (bus.M_AXI_ARREADY && bus.M_AXI_ARVALID) begin
        ar_f = 1; ar_have = 1; ar_a = bus.M_AXI_ARADDR; ar_w = 0; r_w = 0;
        rd_addr_q.push_back(ar_a);
      end
      p_awv = bus.M_AXI_AWVALID && !aw_f; p_awa = bus.M_AXI_AWADDR;
      p_wv  = bus.M_AXI_WVALID && !w_f;   p_wd  = bus.M_AXI_WDATA;
      p_arv = bus.M_AXI_ARVALID && !ar_f; p_ara = bus.M_AXI_ARADDR;
    end
  end

  // reference: what a run with the current fault set must produce
  task automatic model(input logic [31:0] s, output int e_err,
                       output int e_fidx, output int e_nw,
                       output logic [31:0] e_last);
    bit bad;
    e_err = 0; e_fidx = 0; e_nw = 0; e_last = 32'h0;
    for (int i = 0; i < NR; i++) begin
      e_nw = i + 1;
      bad = (i == corrupt_idx) || (i == bresp_idx) || (i == rresp_idx);
      e_last = (i == corrupt_idx) ? 32'hDEAD_0011 : s + 32'(i) * INC;
      if (bad) begin
        if (e_err == 0) e_fidx = i;
        e_err++;
`ifdef REGTEST_STOP_ON_ERR_EN
        break;
`endif
      end
    end
  endtask

  function automatic logic [31:0] exp_addr(input int i);
    return BASE + 32'(i) * STRIDE;
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] s, input int i);
    return s + 32'(i) * INC;
  endfunction

  task automatic run(input logic [31:0] s, output bit ok);
    @(negedge ACLK);
    seed = s; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0; seed = $urandom;
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin ok = 1; break; end
      @(negedge ACLK);
    end
  endtask

  task automatic set_slave(input int a, input int w, input int ar,
                           input int r, input int c, input int b,
                           input int rr);
    aw_dly = a; w_dly = w; ar_dly = ar; r_dly = r;
    corrupt_idx = c; bresp_idx = b; rresp_idx = rr;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
         bus.M_AXI_ARVALID, bus.M_AXI_RREADY} !== 5'b0) begin
      n_bad++; $display("FAIL reset_valids got=%b want=0",
        {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
         bus.M_AXI_ARVALID, bus.M_AXI_RREADY});
    end
    n_cmp++;
    if ({busy, done, pass} !== 3'b000) begin
      n_bad++; $display("FAIL reset_status got=%b want=000", {busy, done, pass});
    end
    n_cmp++;
    if ({err_count, fail_index, last_rdata} !== 41'h0) begin
      n_bad++; $display("FAIL reset_results err=%h fidx=%h last=%h want=0",
        err_count, fail_index, last_rdata);
    end
    n_cmp++;
    if ({bus.M_AXI_WSTRB, bus.M_AXI_AWPROT, bus.M_AXI_ARPROT} !== 10'h3C0) begin
      n_bad++; $display("FAIL reset_strb_prot got=%h/%h/%h want=f/0/0",
        bus.M_AXI_WSTRB, bus.M_AXI_AWPROT, bus.M_AXI_ARPROT);
    end
    n_cmp++;
    if (bus.M_AXI_AWADDR !== BASE) begin
      n_bad++; $display("FAIL reset_addr got=%h want=%h", bus.M_AXI_AWADDR, BASE);
    end
  endtask

  task automatic test_echo();
    bit ok; int wb, e_err, e_fidx, e_nw; logic [31:0] e_last;
    logic [31:0] s = 32'h0101_FFFF;
    set_slave(0, 0, 0, 0, -1, -1, -1);
    wb = wr_addr_q.size();
    model(s, e_err, e_fidx, e_nw, e_last);
    run(s, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL echo_timeout done=%b want=1", done); end
    n_cmp++;
    if ({pass, err_count} !== {1'b1, 5'd0}) begin
      n_bad++; $display("FAIL echo_pass pass=%b err=%0d want 1/0", pass, err_count);
    end
    n_cmp++;
    if (last_rdata !== e_last) begin
      n_bad++; $display("FAIL echo_last got=%h want=%h", last_rdata, e_last);
    end
    n_cmp++;
    if (wr_addr_q.size() - wb != NR) begin
      n_bad++; $display("FAIL echo_nwrites got=%0d want=%0d", wr_addr_q.size() - wb, NR);
    end else begin
      for (int i = 0; i < NR; i++) begin
        n_cmp++;
        if (wr_addr_q[wb+i] !== exp_addr(i) || wr_data_q[wb+i] !== exp_data(s, i)) begin
          n_bad++; $display("FAIL echo_write%0d got=%h:%h want=%h:%h", i,
            wr_addr_q[wb+i], wr_data_q[wb+i], exp_addr(i), exp_data(s, i));
        end
      end
    end
  endtask

  task automatic test_stall();
    bit ok; int a0, w0, p0;
    set_slave(0, 3, 5, 5, -1, -1, -1);
    a0 = aw_cnt; w0 = w_cnt; p0 = proto_err;
    run($urandom, ok);
    n_cmp++;
    if (!ok || pass !== 1'b1) begin
      n_bad++; $display("FAIL stall_pass ok=%b pass=%b want 1/1", ok, pass);
    end
    n_cmp++;
    if (aw_cnt - a0 != NR || w_cnt - w0 != NR) begin
      n_bad++; $display("FAIL stall_accepts aw=%0d w=%0d want=%0d",
        aw_cnt - a0, w_cnt - w0, NR);
    end
    n_cmp++;
    if (proto_err != p0) begin
      n_bad++; $display("FAIL stall_stable errors=%0d want=0", proto_err - p0);
    end
  endtask

  task automatic test_corrupt();
    bit ok; int wb, rb, e_err, e_fidx, e_nw; logic [31:0] e_last;
    logic [31:0] s = $urandom;
    set_slave(0, 0, 0, 0, 2, -1, -1);
    wb = wr_addr_q.size(); rb = rd_addr_q.size();
    model(s, e_err, e_fidx, e_nw, e_last);
    run(s, ok);
    n_cmp++;
    if (!ok || {err_count, fail_index, pass} !== {5'(e_err), 4'(e_fidx), 1'b0}) begin
      n_bad++; $display("FAIL corrupt_result ok=%b err=%0d fidx=%0d pass=%b want %0d/%0d/0",
        ok, err_count, fail_index, pass, e_err, e_fidx);
    end
    n_cmp++;
    if (wr_addr_q.size() - wb != e_nw || rd_addr_q.size() - rb != e_nw) begin
      n_bad++; $display("FAIL corrupt_accesses wr=%0d rd=%0d want=%0d",
        wr_addr_q.size() - wb, rd_addr_q.size() - rb, e_nw);
    end
    n_cmp++;
    if (last_rdata !== e_last) begin
      n_bad++; $display("FAIL corrupt_last got=%h want=%h", last_rdata, e_last);
    end
  endtask

  task automatic test_resp_err();
    bit ok; int e_err, e_fidx, e_nw; logic [31:0] e_last;
    logic [31:0] s = $urandom;
    set_slave(1, 0, 2, 1, -1, 1, 3);
    model(s, e_err, e_fidx, e_nw, e_last);
    run(s, ok);
    n_cmp++;
    if (!ok || {err_count, fail_index, pass} !== {5'(e_err), 4'(e_fidx), 1'b0}) begin
      n_bad++; $display("FAIL resp_result ok=%b err=%0d fidx=%0d pass=%b want %0d/%0d/0",
        ok, err_count, fail_index, pass, e_err, e_fidx);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, seen; int wb;
    logic [31:0] s = $urandom;
    set_slave(1000, 0, 0, 0, -1, -1, -1);
    @(negedge ACLK); seed = $urandom; start = 1'b1;
    @(negedge ACLK); start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.M_AXI_AWVALID) begin seen = 1; break; end
      @(negedge ACLK);
    end
    repeat (2) @(negedge ACLK);
    n_cmp++;
    if (!seen || bus.M_AXI_AWVALID !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_waiting awvalid=%b want=1", bus.M_AXI_AWVALID);
    end
    @(posedge ACLK); #2 ARESET = 1'b1;
    #1;
    n_cmp++;
    if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
         bus.M_AXI_BREADY, bus.M_AXI_RREADY, busy} !== 6'b0) begin
      n_bad++; $display("FAIL rstmid_drop got=%b want=0",
        {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
         bus.M_AXI_BREADY, bus.M_AXI_RREADY, busy});
    end
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    set_slave(0, 0, 0, 0, -1, -1, -1);
    wb = wr_addr_q.size();
    run(s, ok);
    n_cmp++;
    if (!ok || pass !== 1'b1 || wr_addr_q.size() - wb != NR) begin
      n_bad++; $display("FAIL rstmid_rerun ok=%b pass=%b writes=%0d want 1/1/%0d",
        ok, pass, wr_addr_q.size() - wb, NR);
    end
    n_cmp++;
    if (wr_data_q[$] !== exp_data(s, NR - 1)) begin
      n_bad++; $display("FAIL rstmid_data got=%h want=%h", wr_data_q[$], exp_data(s, NR - 1));
    end
  endtask

  task automatic test_start_busy();
    bit ok, mism; int wb;
    logic [31:0] s1 = $urandom;
    logic [31:0] s3 = $urandom;
    set_slave(0, 1, 0, 1, -1, -1, -1);
    wb = wr_addr_q.size();
    @(negedge ACLK); seed = s1; start = 1'b1;
    @(negedge ACLK); start = 1'b0;
    repeat (6) @(negedge ACLK);
    seed = ~s1; start = 1'b1;
    @(negedge ACLK); start = 1'b0;
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin ok = 1; break; end
      @(negedge ACLK);
    end
    mism = (wr_data_q.size() - wb != NR);
    for (int i = 0; i < NR && !mism; i++)
      if (wr_data_q[wb+i] !== exp_data(s1, i)) mism = 1;
    n_cmp++;
    if (!ok || mism || pass !== 1'b1) begin
      n_bad++; $display("FAIL busy_ignore ok=%b seq_bad=%b pass=%b want 1/0/1", ok, mism, pass);
    end
    wb = wr_addr_q.size();
    seed = s3; start = 1'b1;
    @(negedge ACLK); start = 1'b0; seed = ~s3;
    n_cmp++;
    if ({done, busy} !== 2'b01) begin
      n_bad++; $display("FAIL restart_clear done=%b busy=%b want 0/1", done, busy);
    end
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin ok = 1; break; end
      @(negedge ACLK);
    end
    n_cmp++;
    if (!ok || wr_data_q.size() - wb != NR || wr_data_q[wb] !== s3
        || last_rdata !== exp_data(s3, NR - 1)) begin
      n_bad++; $display("FAIL restart_seed ok=%b first=%h last=%h want %h/%h",
        ok, wr_data_q[wb], last_rdata, s3, exp_data(s3, NR - 1));
    end
  endtask

  task automatic test_random();
    bit ok, mism; int wb, rb, e_err, e_fidx, e_nw; logic [31:0] e_last, s;
    for (int it = 0; it < 8; it++) begin
      set_slave(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)));
      s = $urandom;
      wb = wr_addr_q.size(); rb = rd_addr_q.size();
      model(s, e_err, e_fidx, e_nw, e_last);
      run(s, ok);
      n_cmp++;
      if (!ok || {err_count, fail_index, pass, last_rdata} !==
          {5'(e_err), 4'(e_fidx), e_err == 0, e_last}) begin
        n_bad++; $display("FAIL rand%0d_result ok=%b err=%0d fidx=%0d pass=%b last=%h want %0d/%0d/%0d/%h",
          it, ok, err_count, fail_index, pass, last_rdata, e_err, e_fidx, e_err == 0, e_last);
      end
      mism = (wr_addr_q.size() - wb != e_nw) || (rd_addr_q.size() - rb != e_nw);
      for (int i = 0; i < e_nw && !mism; i++)
        if (wr_addr_q[wb+i] !== exp_addr(i) || rd_addr_q[rb+i] !== exp_addr(i)
            || wr_data_q[wb+i] !== exp_data(s, i)) mism = 1;
      n_cmp++;
      if (mism) begin
        n_bad++; $display("FAIL rand%0d_sequence writes=%0d reads=%0d want=%0d",
          it, wr_addr_q.size() - wb, rd_addr_q.size() - rb, e_nw);
      end
    end
  endtask

  initial begin
    ARESET = 1'b1; start = 1'b0; seed = 32'h0;
    repeat (3) @(negedge ACLK);
    test_reset();
    ARESET = 1'b0;
    @(negedge ACLK);
    test_echo();
    test_stall();
    test_corrupt();
    test_resp_err();
    test_reset_mid();
    test_start_busy();
    test_random();
    n_cmp++;
    if (proto_err != 0) begin
      n_bad++; $display("FAIL protocol_total errors=%0d want=0", proto_err);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
